// File: rtl/truncador_pkg.sv
// truncador_pkg -- shared constants for the DAC truncation path.
//
// Holds the default word widths, the offset-binary mid-scale code, the width
// and ceiling of the per-channel saturation counters, and two small helpers
// (channel-tag width, mid-scale code for an arbitrary output width).
// Imported by truncador_dac and saturador_dac.

package truncador_pkg;

  // Default input format: 1 sign, 10 integer and 18 fraction bits.
  localparam int IN_W_DEF   = 29;
  localparam int FRAC_W_DEF = 18;
  localparam int OUT_W_DEF  = 12;
  localparam int NCH_DEF    = 2;

  // Offset-binary code for zero at the default DAC width.
  localparam logic [OUT_W_DEF-1:0] MID_SCALE = 12'h800;

  // Saturation event counters: 16 bits each, they stick at all-ones.
  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A channel tag is always at least one bit wide, even with one channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Offset-binary code of zero for a w-bit DAC: only the MSB set.
  function automatic logic [31:0] mid_scale(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/saturador_dac.sv
// saturador_dac -- combinational clamp plus two's-complement to offset-binary
// conversion for a DAC code.
//
// Parameters:
//   W      width of the signed input value
//   OUT_W  DAC code width (W must exceed OUT_W)
// Ports:
//   y_i     signed value already scaled to DAC LSBs
//   code_o  offset-binary code, y clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   sat_o   high when y_i fell outside that range and was clamped

module saturador_dac
  import truncador_pkg::*;
#(
  parameter int W     = IN_W_DEF + 1,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [W-1:0]     y_i,
  output logic        [OUT_W-1:0] code_o,
  output logic                    sat_o
);

  localparam logic signed [W-1:0] MAX_V = W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [W-1:0] MIN_V = W'(-(64'sd1 <<< (OUT_W - 1)));

  // The positive limit maps to all-ones and the negative limit to all-zeros
  // once the MSB is inverted, so the clamped codes are written directly.
  always_comb begin
    code_o = {~y_i[OUT_W-1], y_i[OUT_W-2:0]};
    sat_o  = 1'b0;
    if (y_i > MAX_V) begin
      code_o = '1;
      sat_o  = 1'b1;
    end else if (y_i < MIN_V) begin
      code_o = '0;
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/truncador_dac.sv
// truncador_dac -- reduces a signed fixed-point filter sample to an
// offset-binary DAC code through a two-stage elastic pipeline.
//
// Stage 1 sign-extends the sample by one bit, optionally adds half an LSB and
// shifts right arithmetically by D = FRAC_W-(OUT_W-1). Stage 2 clamps,
// converts to offset binary and holds the result until the consumer takes it.
// Latency is two cycles; one sample per cycle is sustained without
// backpressure. Samples tagged with a channel >= NCH are accepted and dropped.
//
// Build option: define TRUNCADOR_ROUND_EN to round half up before the shift;
// without it the shift truncates (floor). Latency and ports are the same.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   dato_filtro, canal_in       signed sample and its channel tag
//   in_valid / in_ready         upstream handshake
//   dato_truncado, canal_out    offset-binary code and aligned channel tag
//   out_sat                     current output was clamped
//   out_valid / out_ready       downstream handshake
//   clr_sat                     clears every saturation counter
//   sat_count                   NCH x 16-bit counters, channel k at [16k+15:16k]

module truncador_dac
  import truncador_pkg::*;
#(
  parameter  int IN_W   = IN_W_DEF,
  parameter  int FRAC_W = FRAC_W_DEF,
  parameter  int OUT_W  = OUT_W_DEF,
  parameter  int NCH    = NCH_DEF,
  localparam int CH_W   = ch_width(NCH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_W-1:0]       dato_filtro,
  input  logic [CH_W-1:0]       canal_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      dato_truncado,
  output logic [CH_W-1:0]       canal_out,
  output logic                  out_sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clr_sat,
  output logic [NCH*CNT_W-1:0]  sat_count
);

  localparam int               D   = FRAC_W - (OUT_W - 1);
  localparam int               YW  = IN_W + 1;
  localparam logic [OUT_W-1:0] MID = OUT_W'(mid_scale(OUT_W));

`ifdef TRUNCADOR_ROUND_EN
  localparam logic signed [YW-1:0] RND = YW'(1) << (D - 1);
`else
  localparam logic signed [YW-1:0] RND = '0;
`endif

  // Stage 1: scaled value and tag.
  logic                   v1_q, v1_d;
  logic signed [YW-1:0]   y1_q, y1_d;
  logic [CH_W-1:0]        ch1_q, ch1_d;

  // Stage 2: final code, tag and clamp flag as seen on the outputs.
  logic                   v2_q, v2_d;
  logic [OUT_W-1:0]       code_q, code_d;
  logic [CH_W-1:0]        ch2_q, ch2_d;
  logic                   sat_q, sat_d;

  logic [CNT_W-1:0]       cnt_q [NCH];
  logic [CNT_W-1:0]       cnt_d [NCH];

  logic                   adv2;
  logic                   in_fire;
  logic                   out_fire;
  logic                   ch_ok;
  logic signed [YW-1:0]   x_ext;
  logic signed [YW-1:0]   x_rnd;
  logic [OUT_W-1:0]       code_c;
  logic                   sat_c;

  // Stage 2 can take new data when empty or when its word leaves this cycle;
  // stage 1 can then always move forward, giving !v1 || !v2 || out_ready.
  assign adv2     = !v2_q || out_ready;
  assign in_ready = !v1_q || adv2;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = v2_q && out_ready;
  assign ch_ok    = int'(canal_in) < NCH;

  // One extra sign bit keeps the rounding addition from overflowing.
  assign x_ext = $signed({dato_filtro[IN_W-1], dato_filtro});
  assign x_rnd = x_ext + RND;

  saturador_dac #(
    .W     (YW),
    .OUT_W (OUT_W)
  ) u_saturador (
    .y_i    (y1_q),
    .code_o (code_c),
    .sat_o  (sat_c)
  );

  always_comb begin
    // NOTE: every next-state value is given a default first so no path
    // through this block leaves a variable unassigned and infers a latch.
    v1_d   = v1_q;
    y1_d   = y1_q;
    ch1_d  = ch1_q;
    v2_d   = v2_q;
    code_d = code_q;
    ch2_d  = ch2_q;
    sat_d  = sat_q;

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        code_d = code_c;
        ch2_d  = ch1_q;
        sat_d  = sat_c;
      end
    end

    // A sample with an out-of-range tag is consumed but never marked valid.
    if (in_ready) begin
      v1_d = in_fire && ch_ok;
      if (in_fire) begin
        y1_d  = x_rnd >>> D;
        ch1_d = canal_in;
      end
    end
  end

  // Counters stick at CNT_MAX; clr_sat wins over a simultaneous increment.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_sat) begin
        cnt_d[k] = '0;
      end else if (out_fire && sat_q && (int'(ch2_q) == k) && (cnt_q[k] != CNT_MAX)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values of the previous cycle, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      y1_q   <= '0;
      ch1_q  <= '0;
      v2_q   <= 1'b0;
      code_q <= MID;
      ch2_q  <= '0;
      sat_q  <= 1'b0;
      // NOTE: the counter array is reset element by element because software
      // reads it straight after reset; payload-only storage would not need it.
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      v1_q   <= v1_d;
      y1_q   <= y1_d;
      ch1_q  <= ch1_d;
      v2_q   <= v2_d;
      code_q <= code_d;
      ch2_q  <= ch2_d;
      sat_q  <= sat_d;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign dato_truncado = code_q;
  assign canal_out     = ch2_q;
  assign out_sat       = sat_q;
  assign out_valid     = v2_q;

  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    assign sat_count[k*CNT_W +: CNT_W] = cnt_q[k];
  end

endmodule

// File: doc/truncador_dac.md
TRUNCADOR_DAC -- requirements
Module: truncador_dac

Interface
REQ-001 SHALL have parameter IN_W, 29, input word width (1 sign, 10 integer, 18 fraction bits).
REQ-002 SHALL have parameter FRAC_W, 18, fraction bits in dato_filtro.
REQ-003 SHALL have parameter OUT_W, 12, DAC code width; legal when FRAC_W >= OUT_W and IN_W > FRAC_W.
REQ-004 SHALL have parameter NCH, 2, channel count; CH_W = max(1, clog2(NCH)).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port dato_filtro, input, IN_W, signed two's-complement sample.
REQ-009 SHALL have port canal_in, input, CH_W, channel tag of the sample.
REQ-010 SHALL have ports in_valid (input, 1) and in_ready (output, 1), upstream handshake.
REQ-011 SHALL have port dato_truncado, output, OUT_W, offset-binary DAC code.
REQ-012 SHALL have port canal_out, output, CH_W, channel tag aligned with dato_truncado.
REQ-013 SHALL have port out_sat, output, 1, high when the current output was clamped.
REQ-014 SHALL have ports out_valid (output, 1) and out_ready (input, 1), downstream handshake.
REQ-015 SHALL have port clr_sat, input, 1, clears all saturation counters.
REQ-016 SHALL have port sat_count, output, NCH*16, per-channel saturation counters, channel k in bits [16k+15:16k].

Function
REQ-017 SHALL transfer on a port only when valid and ready are both high in the same cycle.
REQ-018 SHALL use a two-stage elastic pipeline: stage 1 rounds/shifts, stage 2 clamps, converts and holds the output.
REQ-019 SHALL give a latency of exactly 2 cycles from input transfer to out_valid when out_ready stays high.
REQ-020 SHALL drive in_ready = !v1 || !v2 || out_ready, so it sustains one sample per cycle under no backpressure.
REQ-021 SHALL hold dato_truncado, canal_out, out_sat and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL compute D = FRAC_W-(OUT_W-1) and y = x >>> D arithmetically, at width IN_W+1 so there is no overflow.
REQ-023 SHALL clamp y to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set out_sat when clamping occurred.
REQ-024 SHALL output the clamped y with its MSB inverted (offset binary; 0 maps to 0x800 at default widths).
REQ-025 SHALL increment the canal_out counter on each output transfer with out_sat=1, saturating at 0xFFFF without wrapping.
REQ-026 SHALL let clr_sat take priority over a simultaneous increment, leaving the counter at 0.
REQ-027 SHALL drop samples with canal_in >= NCH: they are accepted and do not reach the output.

Reset
REQ-028 SHALL on reset clear v1 and v2, set out_valid=0, dato_truncado=mid-scale (0x800), canal_out=0, out_sat=0 and all sat_count=0.
REQ-029 SHALL on reset discard in-flight samples; in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, when macro TRUNCADOR_ROUND_EN is defined, add 2^(D-1) before the shift (round half up).
REQ-031 SHALL, when TRUNCADOR_ROUND_EN is absent, truncate (floor); latency and interface are identical in both builds.

Structure
REQ-032 SHALL place in package truncador_pkg: default widths, mid-scale constant, counter width (16) and counter maximum.
REQ-033 SHALL implement clamp plus offset conversion in sub-module saturador_dac (combinational, parametrised on width).

Verification
REQ-034 SHALL test x=0 -> dato_truncado 0x800, out_sat 0, out_valid exactly 2 cycles after the input transfer.
REQ-035 SHALL test x=64: ROUND_EN build -> 0x801, no-macro build -> 0x800; x=-1: ROUND_EN -> 0x800, no-macro -> 0x7FF.
REQ-036 SHALL test x=+262144 (+1.0) -> 0xFFF with out_sat=1 and sat_count[ch] +1; x=-262144 -> 0x000 with out_sat=0.
REQ-037 SHALL test out_ready low for 5 cycles while the input streams -> in_ready drops after 2 samples held, output stays stable, no loss or duplication, order preserved.
REQ-038 SHALL test counter preloaded to 0xFFFF with a further saturated sample -> stays 0xFFFF; clr_sat in the same cycle -> 0.
REQ-039 SHALL test reset asserted with both stages full -> out_valid 0 and dato_truncado 0x800 next cycle, no stale sample emitted afterwards.
